// File: rtl/fpga_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared constants and types for the fpga_row configuration loader.
//   BRB_BITS / BSB_BITS / LB_BITS : widths of the three select buses
//   CFG_BITS                      : total configuration frame payload in bits
//   NBYTES                        : data bytes per frame (payload rounded up)
//   SYNC_BYTE                     : frame start marker
//   state_t                       : loader FSM states
// ---------------------------------------------------------------------------
package fpga_cfg_pkg;

  localparam int BRB_BITS    = 180;  // 5 routing blocks x 36
  localparam int BSB_BITS    = 432;  // 4 switch blocks x 108
  localparam int LB_BITS     = 20;   // 4 logic blocks x 5
  localparam int CFG_BITS    = BRB_BITS + BSB_BITS + LB_BITS;
  localparam int NBYTES      = (CFG_BITS + 7) / 8;
  localparam int SHADOW_BITS = NBYTES * 8;
  localparam int CNT_W       = $clog2(NBYTES + 1);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/fpga_config_loader.sv
// ---------------------------------------------------------------------------
// fpga_config_loader
// Writer side of the fpga_row configuration interface. Accepts a byte-serial
// frame (SYNC, NBYTES data bytes LSB-first, checksum byte), assembles it in a
// shadow register, and copies it to the select buses only when the checksum
// verifies, so the fabric never sees a partial configuration.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    byte stream input; in_ready is the accept side
//   abort               drop the frame in progress, back to IDLE
//   brbselect/bsbselect/lbselect  committed configuration slices
//   cfg_valid           outputs hold a committed configuration
//   cfg_done            one-cycle pulse per commit
//   cfg_error           sticky: last frame failed its checksum
//   busy                frame in progress
// ---------------------------------------------------------------------------
module fpga_config_loader
  import fpga_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                abort,
  output logic [BRB_BITS-1:0] brbselect,
  output logic [BSB_BITS-1:0] bsbselect,
  output logic [LB_BITS-1:0]  lbselect,
  output logic                cfg_valid,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                busy
);

  state_t                 state_reg, state_next;
  logic [SHADOW_BITS-1:0] shadow_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [7:0]             sum_reg;
  logic [CFG_BITS-1:0]    cfg_reg;
  logic                   cfg_valid_reg;
  logic                   cfg_done_reg;
  logic                   cfg_error_reg;

  logic                   accept;
  logic                   last_data;
  logic                   sum_ok;
  logic                   do_commit;

  // Next-state and handshake decode
  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg != COMMIT);
    // abort wins over a same-cycle handshake: the byte is simply not taken
    accept     = in_valid && in_ready && !abort;
    last_data  = (cnt_reg == CNT_W'(NBYTES - 1));
    sum_ok     = (8'(sum_reg + in_data) == 8'h00);
    do_commit  = (state_reg == COMMIT) && !abort;

    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept && (in_data == SYNC_BYTE)) state_next = LOAD;
        LOAD:    if (accept && last_data)              state_next = CHECK;
        CHECK:   if (accept)                           state_next = sum_ok ? COMMIT : IDLE;
        COMMIT:                                        state_next = IDLE;
        default:                                       state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame assembly, checksum accumulation and output commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg    <= '0;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      cfg_reg       <= '0;
      cfg_valid_reg <= 1'b0;
      cfg_done_reg  <= 1'b0;
      cfg_error_reg <= 1'b0;
    end else begin
      cfg_done_reg <= do_commit;

      if (do_commit) begin
        cfg_reg       <= shadow_reg[CFG_BITS-1:0];
        cfg_valid_reg <= 1'b1;
      end

      if (accept) begin
        case (state_reg)
          IDLE: begin
            if (in_data == SYNC_BYTE) begin
              cnt_reg       <= '0;
              sum_reg       <= '0;
              cfg_error_reg <= 1'b0;
            end
          end
          LOAD: begin
            // byte k lands at bits [8k+7:8k]
            shadow_reg[{cnt_reg, 3'b000} +: 8] <= in_data;
            cnt_reg <= cnt_reg + CNT_W'(1);
            sum_reg <= sum_reg + in_data;
          end
          CHECK: begin
            if (!sum_ok) cfg_error_reg <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign brbselect = cfg_reg[BRB_BITS-1:0];
  assign bsbselect = cfg_reg[BRB_BITS+BSB_BITS-1:BRB_BITS];
  assign lbselect  = cfg_reg[CFG_BITS-1:BRB_BITS+BSB_BITS];
  assign cfg_valid = cfg_valid_reg;
  assign cfg_done  = cfg_done_reg;
  assign cfg_error = cfg_error_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_fpga_config_loader.sv
// ---------------------------------------------------------------------------
// tb_fpga_config_loader
// Table-driven frames, hand-written corner sequences (abort, abort during
// commit, async reset mid-frame, leading garbage) and randomized frames
// compared against a byte-array reference model.
// ---------------------------------------------------------------------------
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  typedef logic [7:0] frame_t [NBYTES];

  typedef struct {
    bit          rst_first;
    logic [7:0]  fill;
    logic [7:0]  cks;
    bit          gaps;
    int          exp_done;
    bit          exp_err;
    bit          exp_valid;
    logic [7:0]  exp_fill;
    logic [19:0] exp_lb;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                abort;
  logic [BRB_BITS-1:0] brbselect;
  logic [BSB_BITS-1:0] bsbselect;
  logic [LB_BITS-1:0]  lbselect;
  logic                cfg_valid;
  logic                cfg_done;
  logic                cfg_error;
  logic                busy;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int rdy_low_cnt = 0;

  // reference model state
  logic [CFG_BITS-1:0] m_cfg;
  bit                  m_valid;
  bit                  m_err;

  fpga_config_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .brbselect (brbselect),
    .bsbselect (bsbselect),
    .lbselect  (lbselect),
    .cfg_valid (cfg_valid),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_done)  done_cnt    <= done_cnt + 1;
      if (!in_ready) rdy_low_cnt <= rdy_low_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [CFG_BITS-1:0] act,
                     input logic [CFG_BITS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [CFG_BITS-1:0] pack(input frame_t d);
    logic [SHADOW_BITS-1:0] r;
    for (int k = 0; k < NBYTES; k++) r[8*k +: 8] = d[k];
    return r[CFG_BITS-1:0];
  endfunction

  function automatic frame_t fill_frame(input logic [7:0] f);
    frame_t d;
    for (int k = 0; k < NBYTES; k++) d[k] = f;
    return d;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".brb"},   brbselect, m_cfg[BRB_BITS-1:0]);
    chk({tag, ".bsb"},   bsbselect, m_cfg[BRB_BITS+BSB_BITS-1:BRB_BITS]);
    chk({tag, ".lb"},    lbselect,  m_cfg[CFG_BITS-1:BRB_BITS+BSB_BITS]);
    chk({tag, ".valid"}, cfg_valid, m_valid);
    chk({tag, ".err"},   cfg_error, m_err);
    chk({tag, ".busy"},  busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_cfg = '0; m_valid = 0; m_err = 0;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1; in_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends one frame; abort_at >= 0 aborts before data byte abort_at.
  task automatic run_frame(input frame_t d, input logic [7:0] cks, input bit gaps,
                           input int abort_at, input bit abort_commit,
                           input string tag, output int ndone);
    int d0, r0, exp_done;
    logic [7:0] s;
    bit good;
    d0 = done_cnt; r0 = rdy_low_cnt; s = 8'h00;
    put_byte(SYNC_BYTE, gaps);
    m_err = 0;
    for (int k = 0; k < NBYTES; k++) begin
      if (k == abort_at) begin
        // present a byte together with abort: it must be dropped
        abort = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ndone = done_cnt - d0;
        chk({tag, ".abort_done"}, 32'(ndone), 0);
        check_model(tag);
        $display("frame %s: aborted at byte %0d", tag, k);
        return;
      end
      put_byte(d[k], gaps);
      s = s + d[k];
    end
    put_byte(cks, gaps);
    good = (8'(s + cks) == 8'h00);
    chk({tag, ".rdy_commit"}, in_ready, !good);
    if (abort_commit) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_done = (good && !abort_commit) ? 1 : 0;
    chk({tag, ".done_lat"}, cfg_done, exp_done[0]);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, cfg_done, 0);
    if (good && !abort_commit) begin
      m_cfg = pack(d); m_valid = 1;
    end else if (!good) begin
      m_err = 1;
    end
    ndone = done_cnt - d0;
    chk({tag, ".ndone"}, 32'(ndone), 32'(exp_done));
    chk({tag, ".rdy_low"}, 32'(rdy_low_cnt - r0), good ? 1 : 0);
    check_model(tag);
    $display("frame %s: good=%0b done=%0d err=%0b valid=%0b", tag, good, ndone, cfg_error, cfg_valid);
  endtask

  vec_t vecs [6];

  initial begin
    int nd, nd2, aat;
    frame_t fr;
    logic [7:0] s, ck;
    logic [CFG_BITS-1:0] rep;

    vecs[0] = '{1, 8'h01, 8'hB1, 0, 1, 0, 1, 8'h01, 20'h01010};
    vecs[1] = '{1, 8'h01, 8'hB2, 0, 0, 1, 0, 8'h00, 20'h00000};
    vecs[2] = '{1, 8'hFF, 8'h4F, 0, 1, 0, 1, 8'hFF, 20'hFFFFF};
    vecs[3] = '{0, 8'hFF, 8'h4E, 0, 0, 1, 1, 8'hFF, 20'hFFFFF};
    vecs[4] = '{1, 8'h01, 8'hB1, 1, 1, 0, 1, 8'h01, 20'h01010};
    vecs[5] = '{0, 8'hA5, 8'h15, 1, 1, 0, 1, 8'hA5, 20'hA5A5A};

    do_reset();
    chk("rst.done", cfg_done, 0);
    chk("rst.ready", in_ready, 1);
    check_model("rst");

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst_first) do_reset();
      run_frame(fill_frame(vecs[i].fill), vecs[i].cks, vecs[i].gaps, -1, 0,
                $sformatf("vec%0d", i), nd);
      rep = pack(fill_frame(vecs[i].exp_fill));
      chk($sformatf("vec%0d.t_done", i),  32'(nd), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d.t_err", i),   cfg_error, vecs[i].exp_err);
      chk($sformatf("vec%0d.t_valid", i), cfg_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d.t_brb", i),   brbselect, rep[BRB_BITS-1:0]);
      chk($sformatf("vec%0d.t_bsb", i),   bsbselect, rep[BRB_BITS+BSB_BITS-1:BRB_BITS]);
      chk($sformatf("vec%0d.t_lb", i),    lbselect, vecs[i].exp_lb);
    end

    // abort after 40 data bytes, then a full valid frame: one commit total
    do_reset();
    run_frame(fill_frame(8'h33), 8'h00, 0, 40, 0, "abort40", nd);
    run_frame(fill_frame(8'h01), 8'hB1, 0, -1, 0, "after_abort", nd2);
    chk("abort40.total_done", 32'(nd + nd2), 1);
    chk("after_abort.brb0", brbselect[7:0], 8'h01);

    // abort during the COMMIT cycle: no commit, old config kept
    run_frame(fill_frame(8'hFF), 8'h4F, 0, -1, 1, "abort_commit", nd);

    // abort has priority over a SYNC byte presented in IDLE
    abort = 1'b1; in_valid = 1'b1; in_data = SYNC_BYTE;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_sync.busy", busy, 0);

    // leading garbage, async reset mid-LOAD
    put_byte(8'h00, 0);
    chk("garbage0.busy", busy, 0);
    put_byte(8'h12, 0);
    chk("garbage1.busy", busy, 0);
    put_byte(SYNC_BYTE, 0);
    chk("sync.busy", busy, 1);
    for (int k = 0; k < 10; k++) put_byte(8'h5C, 0);
    rst = 1'b1;
    #2;
    chk("async_rst.busy", busy, 0);
    chk("async_rst.valid", cfg_valid, 0);
    chk("async_rst.brb", brbselect, '0);
    chk("async_rst.lb", lbselect, '0);
    @(posedge clk); #1 rst = 1'b0;
    m_cfg = '0; m_valid = 0; m_err = 0;
    check_model("post_rst");
    put_byte(8'h00, 0);
    put_byte(8'h12, 0);
    run_frame(fill_frame(8'h01), 8'hB1, 0, -1, 0, "post_garbage", nd);

    // randomized frames against the model
    for (int t = 0; t < 20; t++) begin
      s = 8'h00;
      for (int k = 0; k < NBYTES; k++) begin
        fr[k] = 8'($urandom);
        s = s + fr[k];
      end
      ck = 8'(8'h00 - s);
      if ($urandom_range(0, 3) == 0) ck = ck + 8'($urandom_range(1, 255));
      aat = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, NBYTES - 1)) : -1;
      run_frame(fr, ck, 1'($urandom_range(0, 1)), aat, 0, $sformatf("rnd%0d", t), nd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
